jtpopeye_objbuf: RTL and testbench

JTPOPEYE_OBJBUF -- requirements
Module: jtpopeye_objbuf

---
 rtl/jtpopeye_objbuf_pkg.sv | 17 +
 rtl/jtpopeye_dual_ram.sv | 33 +++
 rtl/jtpopeye_param.vh | 7 +
 rtl/jtpopeye_objbuf.sv | 181 ++++++++++++++++++
 tb/tb_jtpopeye_objbuf.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/jtpopeye_objbuf_pkg.sv
// Types and widths shared by the object line buffer.
package jtpopeye_objbuf_pkg;
`include "jtpopeye_param.vh"

  localparam int unsigned ObjAw = `OBJ_AW;
  localparam int unsigned ObjCw = `OBJ_CW;
  localparam int unsigned ObjVw = `OBJ_VW;
  localparam int unsigned ObjDw = ObjVw + ObjCw;

  typedef enum logic {StClr, StRun} clr_state_e;

  // Line buffer entry layout: {v, col}.
  function automatic logic [ObjDw-1:0] obj_entry(logic [ObjVw-1:0] v, logic [ObjCw-1:0] col);
    return {v, col};
  endfunction

endpackage

// File: rtl/jtpopeye_dual_ram.sv
// Simple dual-port RAM: one synchronous read port with enable, one write port.
// A read and write to the same address on one edge returns the old contents.
module jtpopeye_dual_ram #(
  parameter int unsigned Aw = 9,
  parameter int unsigned Dw = 8
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [Aw-1:0] rd_addr_i,
  output logic [Dw-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [Aw-1:0] wr_addr_i,
  input  logic [Dw-1:0] wr_data_i
);

  localparam int unsigned Depth = 1 << Aw;

  logic [Dw-1:0] mem_q [Depth];
  logic [Dw-1:0] rd_data_q;

  // Write port
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read; output holds between enabled reads
  always_ff @(posedge clk_i) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/jtpopeye_param.vh
// Shared object line-buffer widths.
`ifndef JTPOPEYE_PARAM_VH
`define JTPOPEYE_PARAM_VH
`define OBJ_AW 9
`define OBJ_CW 6
`define OBJ_VW 2
`endif

// File: rtl/jtpopeye_objbuf.sv
// Double-buffered object line buffer: the renderer fills one bank while the
// other is displayed and cleared behind the beam; banks swap on HBD_n falling.
module jtpopeye_objbuf
  import jtpopeye_objbuf_pkg::*;
(
  input  logic             rst_n,
  input  logic             clk,
  input  logic             cen,
  input  logic [ObjAw-1:0] hcnt,
  input  logic             HBD_n,
  input  logic             VB_n,
  input  logic             wr_en,
  input  logic [ObjAw-1:0] wr_x,
  input  logic [ObjCw-1:0] wr_col,
  input  logic [ObjVw-1:0] wr_v,
  output logic             busy,
  output logic [ObjCw-1:0] objc,
  output logic [ObjVw-1:0] objv
);

  clr_state_e       state_q, state_d;
  logic [ObjAw-1:0] sweep_q, sweep_d;
  logic             bank_sel_q, bank_sel_d;  // read bank; write bank is the other
  logic             hbd_q, hbd_d;
  logic             vb_q, vb_d;
  logic             rd_valid_q, rd_valid_d;
  // Read side: entry read last cen, cleared on this cen
  logic             clr_valid_q, clr_valid_d;
  logic [ObjAw-1:0] clr_addr_q, clr_addr_d;
  logic             clr_bank_q, clr_bank_d;
  // Write stage 1 (read-for-check) registers
  logic             s1_valid_q, s1_valid_d;
  logic [ObjAw-1:0] s1_addr_q, s1_addr_d;
  logic [ObjDw-1:0] s1_data_q, s1_data_d;
  logic             s1_bank_q, s1_bank_d;
  // Bank write that coincided with the stage-1 read
  logic             fwd_hit_q, fwd_hit_d;
  logic             fwd_nz_q, fwd_nz_d;

  logic [ObjAw-1:0] ram_rd_addr [2];
  logic [ObjDw-1:0] ram_rd_data [2];
  logic             ram_we      [2];
  logic [ObjAw-1:0] ram_wr_addr [2];
  logic [ObjDw-1:0] ram_wr_data [2];

  logic             s2_stored_nz, s2_we, clr_we, show, wb;
  logic [ObjDw-1:0] s2_rd, disp_rd;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    jtpopeye_dual_ram #(
      .Aw (ObjAw),
      .Dw (ObjDw)
    ) u_ram (
      .clk_i     (clk),
      .rd_en_i   (cen),
      .rd_addr_i (ram_rd_addr[b]),
      .rd_data_o (ram_rd_data[b]),
      .wr_en_i   (ram_we[b]),
      .wr_addr_i (ram_wr_addr[b]),
      .wr_data_i (ram_wr_data[b])
    );
  end

  // Write decisions for stage 2 and the read-side clear
  always_comb begin
    busy         = (state_q == StClr);
    s2_rd        = ram_rd_data[s1_bank_q];
    s2_stored_nz = fwd_hit_q ? fwd_nz_q : (s2_rd[ObjDw-1 -: ObjVw] != '0);
    s2_we        = cen & s1_valid_q & ~s2_stored_nz & ~busy;
    clr_we       = cen & clr_valid_q & ~busy;
  end

  // Bank port muxing; clear and stage-2 writes always target different banks
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      ram_rd_addr[b] = (bank_sel_q == 1'(b)) ? hcnt : wr_x;
      ram_we[b]      = 1'b0;
      ram_wr_addr[b] = '0;
      ram_wr_data[b] = '0;
      if (busy) begin
        ram_we[b]      = 1'b1;
        ram_wr_addr[b] = sweep_q;
      end else if (clr_we && clr_bank_q == 1'(b)) begin
        ram_we[b]      = 1'b1;
        ram_wr_addr[b] = clr_addr_q;
      end else if (s2_we && s1_bank_q == 1'(b)) begin
        ram_we[b]      = 1'b1;
        ram_wr_addr[b] = s1_addr_q;
        ram_wr_data[b] = s1_data_q;
      end
    end
  end

  // Next-state: clear sweep runs every clk, everything else on cen
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    bank_sel_d  = bank_sel_q;
    hbd_d       = hbd_q;
    vb_d        = vb_q;
    rd_valid_d  = rd_valid_q;
    clr_valid_d = clr_valid_q;
    clr_addr_d  = clr_addr_q;
    clr_bank_d  = clr_bank_q;
    s1_valid_d  = s1_valid_q;
    s1_addr_d   = s1_addr_q;
    s1_data_d   = s1_data_q;
    s1_bank_d   = s1_bank_q;
    fwd_hit_d   = fwd_hit_q;
    fwd_nz_d    = fwd_nz_q;
    wb          = ~bank_sel_q;

    if (state_q == StClr) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == {ObjAw{1'b1}}) state_d = StRun;
    end

    if (cen) begin
      hbd_d = HBD_n;
      if (hbd_q && !HBD_n) bank_sel_d = ~bank_sel_q;
      vb_d        = VB_n;
      rd_valid_d  = ~busy;
      clr_valid_d = ~busy;
      clr_addr_d  = hcnt;
      clr_bank_d  = bank_sel_q;
      s1_valid_d  = wr_en & (wr_v != '0) & ~busy;
      s1_addr_d   = wr_x;
      s1_data_d   = obj_entry(wr_v, wr_col);
      s1_bank_d   = wb;
      // The RAM returns pre-write data when this read collides with a write
      fwd_hit_d   = ram_we[wb] && (ram_wr_addr[wb] == wr_x);
      fwd_nz_d    = (ram_wr_data[wb][ObjDw-1 -: ObjVw] != '0);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClr;
      sweep_q     <= '0;
      bank_sel_q  <= 1'b0;
      hbd_q       <= 1'b0;
      vb_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      clr_valid_q <= 1'b0;
      clr_addr_q  <= '0;
      clr_bank_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      s1_bank_q   <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_nz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      bank_sel_q  <= bank_sel_d;
      hbd_q       <= hbd_d;
      vb_q        <= vb_d;
      rd_valid_q  <= rd_valid_d;
      clr_valid_q <= clr_valid_d;
      clr_addr_q  <= clr_addr_d;
      clr_bank_q  <= clr_bank_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      s1_bank_q   <= s1_bank_d;
      fwd_hit_q   <= fwd_hit_d;
      fwd_nz_q    <= fwd_nz_d;
    end
  end

  // Display output: RAM output register is the one cen of latency
  always_comb begin
    disp_rd = ram_rd_data[clr_bank_q];
    show    = rd_valid_q & vb_q;
    objc    = show ? disp_rd[ObjCw-1:0] : '0;
    objv    = show ? disp_rd[ObjDw-1 -: ObjVw] : '0;
  end

endmodule

// File: tb/tb_jtpopeye_objbuf.sv
// Self-checking bench for the object line buffer against a line-level model.
module tb_jtpopeye_objbuf;

  logic       rst_n = 1'b0;
  logic       clk = 1'b0;
  logic       cen = 1'b0;
  logic [8:0] hcnt = '0;
  logic       HBD_n = 1'b1;
  logic       VB_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [8:0] wr_x = '0;
  logic [5:0] wr_col = '0;
  logic [1:0] wr_v = '0;
  logic       busy;
  logic [5:0] objc;
  logic [1:0] objv;

  int vectors = 0;
  int errors = 0;

  // Model: two banks of {v,col}, read-bank select, last sampled HBD_n
  logic [7:0] mdl [2][512];
  logic       msel;
  logic       mprev;
  logic [7:0] exp_e;

  typedef struct {
    int         h;
    logic [8:0] x;
    logic [5:0] col;
    logic [1:0] v;
  } dwr_t;
  dwr_t dq[$];

  always #5 clk = ~clk;

  jtpopeye_objbuf dut (
    .rst_n  (rst_n),
    .clk    (clk),
    .cen    (cen),
    .hcnt   (hcnt),
    .HBD_n  (HBD_n),
    .VB_n   (VB_n),
    .wr_en  (wr_en),
    .wr_x   (wr_x),
    .wr_col (wr_col),
    .wr_v   (wr_v),
    .busy   (busy),
    .objc   (objc),
    .objv   (objv)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) mdl[b][a] = 8'h0;
    msel  = 1'b0;
    mprev = 1'b1;
    exp_e = 8'h0;
  endtask

  // Apply reset, check reset outputs, then measure the clear sweep length
  task automatic do_reset();
    int n;
    cen   = 1'b0;
    wr_en = 1'b0;
    HBD_n = 1'b1;
    rst_n = 1'b0;
    #3;
    check("reset_out", {7'h0, busy, objv, objc}, {7'h0, 1'b1, 8'h00});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sweep_len", 16'(n), 16'd512);
  endtask

  // One cen: optional idle clock first (outputs must hold), then model + DUT
  task automatic tick(input logic [8:0] hc, input bit hb, input bit vb, input bit we,
                      input logic [8:0] x, input logic [5:0] col, input logic [1:0] v);
    if ($urandom_range(7) == 0) begin
      cen    = 1'b0;
      hcnt   = 9'($urandom);
      HBD_n  = ~hb;
      wr_en  = 1'b1;
      wr_x   = 9'($urandom);
      wr_col = 6'($urandom);
      wr_v   = 2'd3;
      @(posedge clk);
      #1;
      check("hold", {8'h0, objv, objc}, {8'h0, exp_e});
    end
    cen    = 1'b1;
    hcnt   = hc;
    HBD_n  = hb;
    VB_n   = vb;
    wr_en  = we;
    wr_x   = x;
    wr_col = col;
    wr_v   = v;
    exp_e = vb ? mdl[msel][hc] : 8'h0;
    mdl[msel][hc] = 8'h0;
    if (we && v != 2'd0 && mdl[~msel][x][7:6] == 2'd0) mdl[~msel][x] = {v, col};
    if (mprev && !hb) msel = ~msel;
    mprev = hb;
    @(posedge clk);
    #1;
    check("pixel", {8'h0, objv, objc}, {8'h0, exp_e});
  endtask

  // A line of ncen cens; HBD_n falls at h=504. Queued writes override random ones.
  task automatic run_line(input bit rnd, input bit vb, input int ncen,
                          input int probe_h, input logic [7:0] probe_e);
    for (int h = 0; h < ncen; h++) begin
      logic       we;
      logic [8:0] x;
      logic [5:0] col;
      logic [1:0] v;
      dwr_t       d;
      we  = 1'b0;
      x   = '0;
      col = '0;
      v   = '0;
      if (rnd && h != 504) begin
        we  = ($urandom_range(2) == 0);
        x   = ($urandom_range(1) == 0) ? 9'($urandom_range(15)) : 9'($urandom);
        col = 6'($urandom);
        v   = 2'($urandom);
      end
      if (dq.size() > 0 && dq[0].h == h) begin
        d   = dq.pop_front();
        we  = 1'b1;
        x   = d.x;
        col = d.col;
        v   = d.v;
      end
      tick(9'(h), (h < 504), vb, we, x, col, v);
      if (h == probe_h) check("probe", {8'h0, objv, objc}, {8'h0, probe_e});
    end
  endtask

  initial begin
    do_reset();

    // Clean after reset: two lines read zero everywhere
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b1, 512, 0, 8'h00);

    // Single object, displayed next line, cleared after
    dq.push_back('{h: 20, x: 9'd100, col: 6'h2A, v: 2'd2});
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b1, 512, 100, {2'd2, 6'h2A});
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b1, 512, 100, 8'h00);

    // Back-to-back writes to one column: first wins
    dq.push_back('{h: 30, x: 9'd50, col: 6'd5, v: 2'd1});
    dq.push_back('{h: 31, x: 9'd50, col: 6'd9, v: 2'd3});
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b1, 512, 50, {2'd1, 6'd5});

    // Write on the swap cen lands in the old write bank
    dq.push_back('{h: 504, x: 9'd10, col: 6'h11, v: 2'd1});
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b1, 512, 10, {2'd1, 6'h11});
    run_line(1'b0, 1'b1, 512, 10, 8'h00);

    // Blanked line outputs zero but still clears
    dq.push_back('{h: 40, x: 9'd200, col: 6'd7, v: 2'd3});
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b0, 512, 200, 8'h00);
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b1, 512, 200, 8'h00);

    // Randomized traffic
    for (int l = 0; l < 6; l++) run_line(1'b1, ($urandom_range(3) != 0), 512, -1, 8'h0);

    // Reset mid-line with data in both banks
    run_line(1'b1, 1'b1, 512, -1, 8'h0);
    run_line(1'b1, 1'b1, 200, -1, 8'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midline_reset", {7'h0, busy, objv, objc}, {7'h0, 1'b1, 8'h00});
    do_reset();
    run_line(1'b0, 1'b1, 512, -1, 8'h0);
    run_line(1'b0, 1'b1, 512, -1, 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
